// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Each grant is a burst of up to MAX_BURST beats; arbitration costs one idle cycle.
module fifo_wr_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_DATA = 8,
  parameter int MAX_BURST = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic                         i_fifo_full,
  output logic                         o_fifo_wr_en,
  output logic [SIZE_DATA-1:0]         o_fifo_data,
  output logic                         o_grant_valid,
  output logic [IW-1:0]                o_grant_id
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t        r_st;
  logic [IW-1:0] r_grant_id;
  logic [IW-1:0] r_rr_ptr;
  logic [BW-1:0] r_beat_cnt;
  logic          r_grant_valid;

  logic          w_sel_found;
  logic [IW-1:0] w_sel_id;
  logic [IW:0]   w_sum;
  logic          w_in_burst;
  logic          w_cur_valid;
  logic          w_accept;
  logic          w_last_beat;
  logic          w_burst_end;
  logic [IW-1:0] w_ptr_next;

  // Scan offsets from farthest to nearest so the index closest to rr_ptr wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = r_rr_ptr;
    w_sum       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr_ptr} + (IW + 1)'(i);
      if (w_sum >= (IW + 1)'(NUM_REQ)) begin
        w_sum = w_sum - (IW + 1)'(NUM_REQ);
      end
      if (i_req_valid[w_sum[IW-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel_id    = w_sum[IW-1:0];
      end
    end
  end

  assign w_in_burst  = (r_st == ST_BURST);
  assign w_cur_valid = i_req_valid[r_grant_id];
  assign w_accept    = w_in_burst & w_cur_valid & ~i_fifo_full;
  assign w_last_beat = (r_beat_cnt == BW'(MAX_BURST - 1));
  assign w_burst_end = w_in_burst & (~w_cur_valid | (w_accept & w_last_beat));
  // Explicit wrap keeps non-power-of-two NUM_REQ correct.
  assign w_ptr_next  = (r_grant_id == IW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_comb begin
    o_req_ready = '0;
    if (w_in_burst) begin
      o_req_ready[r_grant_id] = ~i_fifo_full;
    end
  end

  assign o_fifo_wr_en  = w_accept;
  assign o_fifo_data   = w_in_burst ? i_req_data[r_grant_id*SIZE_DATA +: SIZE_DATA] : '0;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_id    = r_grant_valid ? r_grant_id : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st          <= ST_IDLE;
      r_grant_id    <= '0;
      r_rr_ptr      <= '0;
      r_beat_cnt    <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      case (r_st)
        ST_IDLE: begin
          if (w_sel_found) begin
            r_grant_id    <= w_sel_id;
            r_beat_cnt    <= '0;
            r_st          <= ST_BURST;
            r_grant_valid <= 1'b1;
          end
        end
        ST_BURST: begin
          if (w_burst_end) begin
            r_st          <= ST_IDLE;
            r_rr_ptr      <= w_ptr_next;
            r_beat_cnt    <= '0;
            r_grant_valid <= 1'b0;
          end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: begin
          r_st          <= ST_IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
